// File: rtl/seg_scan_pkg.sv
// Shared types, segment table and helpers for the seven-segment scan decoder.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned VALUE_W    = NUM_DIGITS * NIB_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    STALE = 2'd2
  } state_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Segment patterns indexed by nibble, bit order {A,B,C,D,E,F,G}
  localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [NUM_DIGITS-1:0] ndigit;
    logic [SEG_W-1:0]      seg;
    logic                  dp;
  } sample_t;

  localparam sample_t SAMPLE_IDLE = '{ndigit: '1, seg: '0, dp: 1'b0};

  typedef struct packed {
    logic [NIB_W-1:0] nibble;
    logic             blank;
    logic             error;
  } hex_t;

  function automatic logic multi_low(input logic [NUM_DIGITS-1:0] ndigit);
    return $countones(~ndigit) > 1;
  endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup: seven segment lines back to a hex nibble,
// flagging all-off (blank) and unrecognised (error) patterns.
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output hex_t             hex_c
);

  always_comb begin
    hex_c = '0;
    if (seg == SEG_BLANK) begin
      hex_c.blank = 1'b1;
    end else begin
      hex_c.error = 1'b1;
      for (int unsigned i = 0; i < 16; i++) begin
        if (seg == HEX_SEG[i]) begin
          hex_c.nibble = NIB_W'(i);
          hex_c.error  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment scan, filters each digit dwell for
// stability, decodes it and publishes complete four-digit frames.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [NUM_DIGITS-1:0] nDigit,
  input  logic                  SegA,
  input  logic                  SegB,
  input  logic                  SegC,
  input  logic                  SegD,
  input  logic                  SegE,
  input  logic                  SegF,
  input  logic                  SegG,
  input  logic                  DP,
  output logic [VALUE_W-1:0]    Value,
  output logic [NUM_DIGITS-1:0] DPs,
  output logic [NUM_DIGITS-1:0] Blank,
  output logic [NUM_DIGITS-1:0] SegError,
  output logic                  Valid,
  output logic                  Overlap,
  output logic                  Stale
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_PRE = SET_W'(SETTLE_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  sample_t in_c, s_q, p_q;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [TO_W-1:0]  tmo_q, tmo_d;
  state_t           state_q, state_d;
  logic             stable_c, capture_c, frame_done_c, stale_set_c;
  logic [NUM_DIGITS-1:0] sel_c, mask_q, mask_d, mask_upd_c;
  logic [NUM_DIGITS-1:0][NIB_W-1:0] nib_q, nib_c;
  logic [NUM_DIGITS-1:0] dp_q, dp_c, blank_q, blank_c, err_q, err_c;
  hex_t             hex_c;

  assign in_c  = {nDigit, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP};
  assign sel_c = ~s_q.ndigit;

  seg7_to_hex u_seg7_to_hex (
    .seg   (s_q.seg),
    .hex_c (hex_c)
  );

  // Two-stage sampling and dwell stability counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s_q      <= SAMPLE_IDLE;
      p_q      <= SAMPLE_IDLE;
      settle_q <= '0;
    end else begin
      s_q      <= in_c;
      p_q      <= s_q;
      settle_q <= settle_d;
    end
  end

  // Capture fires only on the transition into the saturated count
  always_comb begin
    stable_c  = (s_q == p_q) && (s_q.ndigit != '1) && !multi_low(s_q.ndigit);
    settle_d  = '0;
    capture_c = 1'b0;
    if (stable_c) begin
      settle_d  = (settle_q == SET_MAX) ? SET_MAX : settle_q + 1'b1;
      capture_c = (settle_q == SET_PRE);
    end
  end

  always_comb begin
    nib_c      = nib_q;
    dp_c       = dp_q;
    blank_c    = blank_q;
    err_c      = err_q;
    mask_upd_c = mask_q;
    if (capture_c) begin
      for (int k = 0; k < int'(NUM_DIGITS); k++) begin
        if (sel_c[k]) begin
          nib_c[k]   = hex_c.nibble;
          dp_c[k]    = s_q.dp;
          blank_c[k] = hex_c.blank;
          err_c[k]   = hex_c.error;
        end
      end
      mask_upd_c = mask_q | sel_c;
    end
    frame_done_c = capture_c && (mask_upd_c == '1);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM; a capture in the same cycle as the timeout takes priority
  always_comb begin
    state_d     = state_q;
    stale_set_c = 1'b0;
    tmo_d       = '0;
    mask_d      = mask_upd_c;
    case (state_q)
      IDLE: begin
        if (capture_c) state_d = SCAN;
      end
      SCAN: begin
        if (!capture_c) begin
          if (tmo_q == TO_MAX) begin
            state_d     = STALE;
            stale_set_c = 1'b1;
            mask_d      = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      STALE: begin
        if (capture_c) state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase
    if (frame_done_c) mask_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      tmo_q    <= '0;
      mask_q   <= '0;
      nib_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      Value    <= '0;
      DPs      <= '0;
      Blank    <= '0;
      SegError <= '0;
      Valid    <= 1'b0;
      Overlap  <= 1'b0;
      Stale    <= 1'b0;
    end else begin
      tmo_q   <= tmo_d;
      mask_q  <= mask_d;
      nib_q   <= nib_c;
      dp_q    <= dp_c;
      blank_q <= blank_c;
      err_q   <= err_c;
      Valid   <= frame_done_c;
      Overlap <= multi_low(nDigit);
      if (frame_done_c) begin
        Value    <= nib_c;
        DPs      <= dp_c;
        Blank    <= blank_c;
        SegError <= err_c;
        Stale    <= 1'b0;
      end else if (stale_set_c) begin
        Stale <= 1'b1;
      end
    end
  end

endmodule
